c3_custom_heap_instruction: RTL and testbench
=============================================

// Module: c3_custom_heap_instruction
// PURPOSE
//  Custom-instruction execution unit with an on-chip binary min-heap (priority queue).
//  Accepts push/pop/peek commands tagged with register identifiers, one at a time.
//  Returns the result plus the echoed tags and the current heap size.
//  Sits beside the core's ALU as a multi-cycle custom functional unit.
// PARAMETERS
//  DEPTH   16  heap capacity in 32-bit entries (power of 2, >=2)
//  AW      4   index width, $clog2(DEPTH)
// PORTS
//  clk            in   1   single clock, rising edge
//  reset          in   1   asynchronous, active-low reset (0 = reset)
//  in_v           in   1   command valid; sampled only in IDLE
//  rd             in   5   destination register tag, echoed on out_rd
//  vrd1           in   3   opcode: 000 push, 001 pop, 010 peek, others NOP
//  vrd2           in   3   auxiliary tag, echoed on out_vrd2
//  in_data        in   32  push value (unsigned)
//  in_heap_addr   in   32  heap base-address tag, echoed on out_heap_addr
//  in_heap_size   in   32  capacity limit; 0 or >=DEPTH means DEPTH
//  out_v          out  1   one-cycle completion pulse
//  out_rd         out  5   registered rd of the completed command
//  out_vrd1       out  3   registered opcode of the completed command
//  out_vrd2       out  3   registered vrd2 of the completed command
//  out_data       out  32  result value, held until the next completion
//  out_heap_size  out  32  element count, zero-extended from AW+1 bits
//  out_heap_addr  out  32  registered in_heap_addr of the completed command
// BEHAVIOUR
//  Reset (reset=0, async): every output is 0, count=0, FSM=IDLE. Storage contents are don't-care.
//  FSM states: IDLE -> EXEC -> (SIFT_UP | SIFT_DOWN)* -> DONE -> IDLE.
//  IDLE: on in_v=1 latch rd, vrd1, vrd2, in_data, in_heap_addr, and cap = min(in_heap_size or DEPTH, DEPTH). Go to EXEC.
//   in_v in any state other than IDLE is ignored and the command is dropped.
//  EXEC, push: if count<cap, write heap[count]=data, idx=count, count+1, go to SIFT_UP.
//   If full: no change, result=0, go to DONE.
//  EXEC, pop: if count>0, result=heap[0], heap[0]=heap[count-1], count-1, idx=0, go to SIFT_DOWN.
//   If empty: result=0, go to DONE.
//  EXEC, peek: result = (count>0) ? heap[0] : 0, go to DONE. NOP: result=0, go to DONE.
//  SIFT_UP, one level per cycle: if idx>0 and heap[idx] < heap[(idx-1)/2], swap and set idx=parent.
//   Otherwise result=pushed value, go to DONE.
//  SIFT_DOWN, one level per cycle: pick the smaller valid child, lower-index child on a tie.
//   If that child < heap[idx], swap and set idx=child. Otherwise go to DONE.
//  Comparisons are unsigned 32-bit; equal values are never swapped.
//  DONE: out_v=1 for exactly one cycle. In the same cycle update out_data=result, out_heap_size=count and all echoed tags. Go to IDLE.
//  Latency from the accept edge to the out_v-high edge is 3 + number of swaps, so at most 3+AW for push or pop.
//  IDLE is re-entered the cycle after out_v, and a new command is accepted on that edge.
//  Outside DONE: out_v=0, and all other outputs hold their values.
//  Reset asserted mid-operation aborts immediately: heap is emptied and outputs return to 0.
// TESTING
//  Reset held low 100 ns: all outputs 0. Pop on empty -> out_v, out_data=0, out_heap_size=0.
//  Push 10, 20, 15 (tags rd=0, vrd1=000), each after the previous out_v:
//   out_heap_size 1,2,3; out_data 10,20,15.
//  Then pop (vrd1=001) -> out_data=10, out_heap_size=2. Next pop -> 15, next pop -> 20.
//  Push 5,4,3,2,1 -> peek returns 1 with no size change.
//   Push of 1 into a heap of 4 has out_v 5 cycles after accept (2 swaps).
//  Fill DEPTH=16 entries, then push 99 -> out_data=0, size stays 16.
//   Then pop 16 times -> values in ascending order.
//  in_heap_size=2: a third push is rejected, size stays 2.
//   Echo check: rd=7, vrd2=5, in_heap_addr=0x1000 appear on the completing outputs.
//  in_v pulsed while busy is dropped. Reset asserted mid-SIFT_DOWN -> size 0, out_v 0.

Source files
------------

// File: rtl/c3_custom_heap_instruction.sv
// Custom-instruction unit holding a binary min-heap: push/pop/peek with one
// sift level per cycle; tags are echoed and the heap size is reported on completion.
module c3_custom_heap_instruction #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_v,
    input  logic [4:0]  rd,
    input  logic [2:0]  vrd1,
    input  logic [2:0]  vrd2,
    input  logic [31:0] in_data,
    input  logic [31:0] in_heap_addr,
    input  logic [31:0] in_heap_size,
    output logic        out_v,
    output logic [4:0]  out_rd,
    output logic [2:0]  out_vrd1,
    output logic [2:0]  out_vrd2,
    output logic [31:0] out_data,
    output logic [31:0] out_heap_size,
    output logic [31:0] out_heap_addr
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned XW = AW + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_SIFT_UP,
        S_SIFT_DOWN,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [31:0]    r_heap [DEPTH];
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  r_cap;
    logic [AW-1:0]  r_idx;
    logic [4:0]     r_rd;
    logic [2:0]     r_op;
    logic [2:0]     r_vrd2;
    logic [31:0]    r_data;
    logic [31:0]    r_addr;
    logic [31:0]    r_result;

    logic [CW-1:0]  w_cap;
    logic [AW-1:0]  w_parent;
    logic [XW-1:0]  w_left;
    logic [XW-1:0]  w_right;
    logic           w_left_ok;
    logic           w_right_ok;
    logic [31:0]    w_left_val;
    logic [31:0]    w_right_val;
    logic [AW-1:0]  w_child;
    logic [31:0]    w_child_val;
    logic [31:0]    w_cur_val;
    logic [31:0]    w_parent_val;

    // Zero or oversized capacity requests clamp to the physical depth.
    assign w_cap = (in_heap_size == 32'd0 || in_heap_size >= 32'(DEPTH))
                   ? CW'(DEPTH) : in_heap_size[CW-1:0];

    // Neighbour indices of the current sift position; smaller child wins, left on a tie.
    assign w_parent     = (r_idx - AW'(1)) >> 1;
    assign w_left       = {1'b0, r_idx, 1'b0} + XW'(1);
    assign w_right      = w_left + XW'(1);
    assign w_left_ok    = w_left < XW'(r_count);
    assign w_right_ok   = w_right < XW'(r_count);
    assign w_left_val   = r_heap[w_left[AW-1:0]];
    assign w_right_val  = r_heap[w_right[AW-1:0]];
    assign w_child      = (w_right_ok && (w_right_val < w_left_val))
                          ? w_right[AW-1:0] : w_left[AW-1:0];
    assign w_child_val  = r_heap[w_child];
    assign w_cur_val    = r_heap[r_idx];
    assign w_parent_val = r_heap[w_parent];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_cap         <= '0;
            r_idx         <= '0;
            r_rd          <= '0;
            r_op          <= '0;
            r_vrd2        <= '0;
            r_data        <= '0;
            r_addr        <= '0;
            r_result      <= '0;
            out_v         <= 1'b0;
            out_rd        <= '0;
            out_vrd1      <= '0;
            out_vrd2      <= '0;
            out_data      <= '0;
            out_heap_size <= '0;
            out_heap_addr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_heap[i] <= '0;
            end
        end else begin
            out_v <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_v) begin
                        r_rd    <= rd;
                        r_op    <= vrd1;
                        r_vrd2  <= vrd2;
                        r_data  <= in_data;
                        r_addr  <= in_heap_addr;
                        r_cap   <= w_cap;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (r_op)
                        3'b000: begin
                            if (r_count < r_cap) begin
                                r_heap[r_count[AW-1:0]] <= r_data;
                                r_idx   <= r_count[AW-1:0];
                                r_count <= r_count + CW'(1);
                                r_state <= S_SIFT_UP;
                            end else begin
                                r_result <= '0;
                                r_state  <= S_DONE;
                            end
                        end
                        3'b001: begin
                            if (r_count != '0) begin
                                r_result  <= r_heap[0];
                                r_heap[0] <= r_heap[AW'(r_count - CW'(1))];
                                r_count   <= r_count - CW'(1);
                                r_idx     <= '0;
                                r_state   <= S_SIFT_DOWN;
                            end else begin
                                r_result <= '0;
                                r_state  <= S_DONE;
                            end
                        end
                        3'b010: begin
                            r_result <= (r_count != '0) ? r_heap[0] : 32'd0;
                            r_state  <= S_DONE;
                        end
                        default: begin
                            r_result <= '0;
                            r_state  <= S_DONE;
                        end
                    endcase
                end
                S_SIFT_UP: begin
                    if (r_idx != '0 && w_cur_val < w_parent_val) begin
                        r_heap[r_idx]    <= w_parent_val;
                        r_heap[w_parent] <= w_cur_val;
                        r_idx            <= w_parent;
                    end else begin
                        r_result <= r_data;
                        r_state  <= S_DONE;
                    end
                end
                S_SIFT_DOWN: begin
                    if (w_left_ok && w_child_val < w_cur_val) begin
                        r_heap[r_idx]   <= w_child_val;
                        r_heap[w_child] <= w_cur_val;
                        r_idx           <= w_child;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    out_v         <= 1'b1;
                    out_data      <= r_result;
                    out_heap_size <= 32'(r_count);
                    out_rd        <= r_rd;
                    out_vrd1      <= r_op;
                    out_vrd2      <= r_vrd2;
                    out_heap_addr <= r_addr;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c3_custom_heap_instruction.sv
// Directed bench for the min-heap custom instruction: ordering, latency,
// capacity limits, tag echo, busy-drop and mid-operation reset.
module tb_c3_custom_heap_instruction;

    logic        clk;
    logic        reset;
    logic        in_v;
    logic [4:0]  rd;
    logic [2:0]  vrd1;
    logic [2:0]  vrd2;
    logic [31:0] in_data;
    logic [31:0] in_heap_addr;
    logic [31:0] in_heap_size;
    logic        out_v;
    logic [4:0]  out_rd;
    logic [2:0]  out_vrd1;
    logic [2:0]  out_vrd2;
    logic [31:0] out_data;
    logic [31:0] out_heap_size;
    logic [31:0] out_heap_addr;

    int checks   = 0;
    int failures = 0;

    c3_custom_heap_instruction dut (
        .clk           (clk),
        .reset         (reset),
        .in_v          (in_v),
        .rd            (rd),
        .vrd1          (vrd1),
        .vrd2          (vrd2),
        .in_data       (in_data),
        .in_heap_addr  (in_heap_addr),
        .in_heap_size  (in_heap_size),
        .out_v         (out_v),
        .out_rd        (out_rd),
        .out_vrd1      (out_vrd1),
        .out_vrd2      (out_vrd2),
        .out_data      (out_data),
        .out_heap_size (out_heap_size),
        .out_heap_addr (out_heap_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one command from a point just after a clock edge and waits for out_v;
    // lat = edges from accept to out_v, or -1 if it never arrived.
    task automatic do_cmd(input logic [2:0] op, input logic [31:0] data,
                          input logic [31:0] hsize, output int lat);
        vrd1         = op;
        in_data      = data;
        in_heap_size = hsize;
        in_v         = 1'b1;
        @(posedge clk);
        #1;
        in_v = 1'b0;
        lat  = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (out_v) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #100;
        checks++; if (out_v !== 1'b0) begin failures++; $display("FAIL reset_out_v got=%0d exp=0", out_v); end
        checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        checks++; if (out_heap_size !== 32'd0) begin failures++; $display("FAIL reset_size got=%0d exp=0", out_heap_size); end
        checks++; if (out_rd !== 5'd0 || out_vrd1 !== 3'd0 || out_vrd2 !== 3'd0) begin
            failures++; $display("FAIL reset_tags got=%0d/%0d/%0d exp=0/0/0", out_rd, out_vrd1, out_vrd2);
        end
        checks++; if (out_heap_addr !== 32'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", out_heap_addr); end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_empty_pop();
        int lat;
        do_cmd(3'b001, 32'd0, 32'd0, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL empty_pop_lat got=%0d exp=2", lat); end
        checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL empty_pop_data got=%0d exp=0", out_data); end
        checks++; if (out_heap_size !== 32'd0) begin failures++; $display("FAIL empty_pop_size got=%0d exp=0", out_heap_size); end
        checks++; if (out_vrd1 !== 3'b001) begin failures++; $display("FAIL empty_pop_op got=%0d exp=1", out_vrd1); end
    endtask

    task automatic test_push_pop_basic();
        logic [31:0] pv [3] = '{32'd10, 32'd20, 32'd15};
        logic [31:0] ov [3] = '{32'd10, 32'd15, 32'd20};
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_cmd(3'b000, pv[i], 32'd0, lat);
            checks++; if (lat !== 3) begin failures++; $display("FAIL push%0d_lat got=%0d exp=3", i, lat); end
            checks++; if (out_data !== pv[i]) begin failures++; $display("FAIL push%0d_data got=%0d exp=%0d", i, out_data, pv[i]); end
            checks++; if (out_heap_size !== 32'(i + 1)) begin failures++; $display("FAIL push%0d_size got=%0d exp=%0d", i, out_heap_size, i + 1); end
        end
        for (int i = 0; i < 3; i++) begin
            do_cmd(3'b001, 32'd0, 32'd0, lat);
            checks++; if (lat !== 3) begin failures++; $display("FAIL pop%0d_lat got=%0d exp=3", i, lat); end
            checks++; if (out_data !== ov[i]) begin failures++; $display("FAIL pop%0d_data got=%0d exp=%0d", i, out_data, ov[i]); end
            checks++; if (out_heap_size !== 32'(2 - i)) begin failures++; $display("FAIL pop%0d_size got=%0d exp=%0d", i, out_heap_size, 2 - i); end
        end
    endtask

    task automatic test_peek_latency();
        // Swap counts: 5 ->0, 4 ->1, 3 ->1, 2 ->2, 1 ->2.
        int exp_lat [5] = '{3, 4, 4, 5, 5};
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_cmd(3'b000, 32'(5 - i), 32'd0, lat);
            checks++; if (lat !== exp_lat[i]) begin failures++; $display("FAIL desc_push%0d_lat got=%0d exp=%0d", i, lat, exp_lat[i]); end
        end
        do_cmd(3'b010, 32'd0, 32'd0, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL peek_lat got=%0d exp=2", lat); end
        checks++; if (out_data !== 32'd1) begin failures++; $display("FAIL peek_data got=%0d exp=1", out_data); end
        checks++; if (out_heap_size !== 32'd5) begin failures++; $display("FAIL peek_size got=%0d exp=5", out_heap_size); end
        for (int i = 0; i < 5; i++) begin
            do_cmd(3'b001, 32'd0, 32'd0, lat);
            checks++; if (out_data !== 32'(i + 1) || out_heap_size !== 32'(4 - i)) begin
                failures++; $display("FAIL desc_pop%0d got=%0d/%0d exp=%0d/%0d", i, out_data, out_heap_size, i + 1, 4 - i);
            end
        end
    endtask

    task automatic test_fill_and_drain();
        logic [31:0] fv [16] = '{32'd50, 32'd3, 32'd77, 32'd12, 32'd3, 32'd90, 32'd1, 32'd64,
                                 32'd33, 32'd8, 32'd21, 32'd100, 32'd5, 32'd42, 32'd17, 32'd9};
        logic [31:0] sv [16] = '{32'd1, 32'd3, 32'd3, 32'd5, 32'd8, 32'd9, 32'd12, 32'd17,
                                 32'd21, 32'd33, 32'd42, 32'd50, 32'd64, 32'd77, 32'd90, 32'd100};
        int lat;
        for (int i = 0; i < 16; i++) begin
            do_cmd(3'b000, fv[i], 32'd0, lat);
            checks++; if (lat < 3 || lat > 7 || out_data !== fv[i] || out_heap_size !== 32'(i + 1)) begin
                failures++; $display("FAIL fill%0d got lat=%0d data=%0d size=%0d exp data=%0d size=%0d", i, lat, out_data, out_heap_size, fv[i], i + 1);
            end
        end
        do_cmd(3'b000, 32'd99, 32'd0, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL full_push_lat got=%0d exp=2", lat); end
        checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL full_push_data got=%0d exp=0", out_data); end
        checks++; if (out_heap_size !== 32'd16) begin failures++; $display("FAIL full_push_size got=%0d exp=16", out_heap_size); end
        for (int i = 0; i < 16; i++) begin
            do_cmd(3'b001, 32'd0, 32'd0, lat);
            checks++; if (lat < 3 || lat > 7 || out_data !== sv[i] || out_heap_size !== 32'(15 - i)) begin
                failures++; $display("FAIL drain%0d got lat=%0d data=%0d size=%0d exp data=%0d size=%0d", i, lat, out_data, out_heap_size, sv[i], 15 - i);
            end
        end
    endtask

    task automatic test_cap_and_echo();
        int lat;
        rd           = 5'd7;
        vrd2         = 3'd5;
        in_heap_addr = 32'h0000_1000;
        do_cmd(3'b000, 32'd30, 32'd2, lat);
        do_cmd(3'b000, 32'd40, 32'd2, lat);
        checks++; if (out_heap_size !== 32'd2) begin failures++; $display("FAIL cap_fill_size got=%0d exp=2", out_heap_size); end
        do_cmd(3'b000, 32'd50, 32'd2, lat);
        checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL cap_reject_data got=%0d exp=0", out_data); end
        checks++; if (out_heap_size !== 32'd2) begin failures++; $display("FAIL cap_reject_size got=%0d exp=2", out_heap_size); end
        checks++; if (out_rd !== 5'd7) begin failures++; $display("FAIL echo_rd got=%0d exp=7", out_rd); end
        checks++; if (out_vrd2 !== 3'd5) begin failures++; $display("FAIL echo_vrd2 got=%0d exp=5", out_vrd2); end
        checks++; if (out_heap_addr !== 32'h0000_1000) begin failures++; $display("FAIL echo_addr got=%0h exp=1000", out_heap_addr); end
        checks++; if (out_vrd1 !== 3'b000) begin failures++; $display("FAIL echo_op got=%0d exp=0", out_vrd1); end
        rd           = 5'd0;
        vrd2         = 3'd0;
        in_heap_addr = 32'd0;
    endtask

    task automatic test_busy_drop();
        int lat;
        int extra;
        vrd1         = 3'b000;
        in_data      = 32'd25;
        in_heap_size = 32'd0;
        in_v         = 1'b1;
        @(posedge clk);
        #1;
        vrd1 = 3'b001;
        lat  = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) in_v = 1'b0;
            @(posedge clk);
            #1;
            if (out_v) begin
                lat = c;
                break;
            end
        end
        in_v = 1'b0;
        checks++; if (lat !== 4) begin failures++; $display("FAIL busy_push_lat got=%0d exp=4", lat); end
        checks++; if (out_data !== 32'd25 || out_heap_size !== 32'd3) begin
            failures++; $display("FAIL busy_push got=%0d/%0d exp=25/3", out_data, out_heap_size);
        end
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_v) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL busy_drop_pulses got=%0d exp=0", extra); end
        do_cmd(3'b111, 32'd0, 32'd0, lat);
        checks++; if (out_data !== 32'd0 || out_heap_size !== 32'd3 || out_vrd1 !== 3'b111) begin
            failures++; $display("FAIL nop got=%0d/%0d/%0d exp=0/3/7", out_data, out_heap_size, out_vrd1);
        end
        do_cmd(3'b010, 32'd0, 32'd0, lat);
        checks++; if (out_data !== 32'd25) begin failures++; $display("FAIL busy_peek got=%0d exp=25", out_data); end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        vrd1 = 3'b001;
        in_v = 1'b1;
        @(posedge clk);
        #1;
        in_v = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (out_v !== 1'b0 || out_heap_size !== 32'd0 || out_data !== 32'd0) begin
            failures++; $display("FAIL midreset got v=%0d size=%0d data=%0d exp 0/0/0", out_v, out_heap_size, out_data);
        end
        #5;
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_cmd(3'b001, 32'd0, 32'd0, lat);
        checks++; if (lat !== 2 || out_data !== 32'd0 || out_heap_size !== 32'd0) begin
            failures++; $display("FAIL post_reset_pop got lat=%0d data=%0d size=%0d exp 2/0/0", lat, out_data, out_heap_size);
        end
    endtask

    initial begin
        reset        = 1'b0;
        in_v         = 1'b0;
        rd           = '0;
        vrd1         = '0;
        vrd2         = '0;
        in_data      = '0;
        in_heap_addr = '0;
        in_heap_size = '0;
        test_reset();
        test_empty_pop();
        test_push_pop_basic();
        test_peek_latency();
        test_fill_and_drain();
        test_cap_and_echo();
        test_busy_drop();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
